// File: rtl/sub_serial_if.sv
// sub_serial_if: start/operand/result bundle for the bit-serial subtractor
interface sub_serial_if #(parameter int WIDTH = 8);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             borrow_out;
  logic             done;
  logic             busy;
  modport master (output en, a, b, input out, borrow_out, done, busy);
  modport slave  (input en, a, b, output out, borrow_out, done, busy);
endinterface

// File: rtl/sub_serial.sv
// sub_serial: LSB-first bit-serial a - b; define SUB_SERIAL_SAT_EN to clamp underflow to zero
module sub_serial #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
  sub_serial_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res;
  logic [CNT_W-1:0] count;
  logic             borrow, brw_out, done_r;
  logic             d, nb, last, start;
  assign d     = a_reg[0] ^ b_reg[0] ^ borrow;
  assign nb    = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
  assign last  = count == CNT_W'(WIDTH - 1);
  assign start = (state == IDLE || state == DONE) && bus.en;
  always_comb begin
    nxt = IDLE;
    nxt = (state == SUB) ? (last ? DONE : SUB) : (start ? SUB : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res     <= '0;
      count   <= '0;
      borrow  <= 1'b0;
      brw_out <= 1'b0;
      done_r  <= 1'b0;
    end else if (start) begin
      a_reg   <= bus.a;
      b_reg   <= bus.b;
      res     <= '0;
      count   <= '0;
      borrow  <= 1'b0;
      brw_out <= 1'b0;
      done_r  <= 1'b0;
    end else if (state == SUB) begin
`ifdef SUB_SERIAL_SAT_EN
      res     <= (last && nb) ? '0 : {d, res[WIDTH-1:1]};
`else
      res     <= {d, res[WIDTH-1:1]};
`endif
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      borrow  <= nb;
      count   <= count + 1'b1;
      if (last) begin
        brw_out <= nb;
        done_r  <= 1'b1;
      end
    end else if (state == DONE) begin
      done_r  <= 1'b0;
    end
  end
  assign bus.out        = res;
  assign bus.borrow_out = brw_out;
  assign bus.done       = done_r;
  assign bus.busy       = state == SUB;
endmodule
